// File: rtl/arith_share_arbiter_if.sv
// rtl/arith_share_arbiter_if.sv - request/response bundle for the shared sum/product unit
interface arith_share_arbiter_if #(
    parameter int WIDTH = 8
);
    logic                   req0_valid;
    logic                   req0_ready;
    logic [WIDTH-1:0]       req0_a;
    logic [WIDTH-1:0]       req0_b;
    logic                   req1_valid;
    logic                   req1_ready;
    logic [WIDTH-1:0]       req1_a;
    logic [WIDTH-1:0]       req1_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic                   rsp_id;
    logic [WIDTH:0]         rsp_sum;
    logic [2*WIDTH-1:0]     rsp_product;
    logic                   busy;
    logic [15:0]            op_count;

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_product, busy, op_count
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_product, busy, op_count
    );
endinterface

// File: rtl/arith_share_arbiter.sv
// rtl/arith_share_arbiter.sv - round-robin shared adder and shift-add multiplier
module arith_share_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    arith_share_arbiter_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t               state, state_next;
    logic                 ptr;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [2*WIDTH-1:0]   acc, addend;
    logic [CW-1:0]        cnt;
    logic                 grant0, grant1, accept, mul_last, rsp_fire;
    logic [WIDTH-1:0]     sel_a, sel_b;
    logic                 id_q, valid_q;
    logic [WIDTH:0]       sum_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [15:0]          count_q;

    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        state_next = state;
        // With both valid, ptr picks the winner; a lone requester always wins.
        if (bus.req0_valid && (!bus.req1_valid || !ptr)) begin
            grant0 = 1'b1;
        end else if (bus.req1_valid) begin
            grant1 = 1'b1;
        end
        accept   = (state == IDLE) && (grant0 || grant1);
        mul_last = (state == MUL) && (cnt == CW'(WIDTH - 1));
        rsp_fire = (state == DONE) && bus.rsp_ready;
        sel_a    = grant1 ? bus.req1_a : bus.req0_a;
        sel_b    = grant1 ? bus.req1_b : bus.req0_b;
        addend   = b_q[cnt] ? ({{WIDTH{1'b0}}, a_q} << cnt) : '0;
        case (state)
            IDLE:    if (accept)   state_next = MUL;
            MUL:     if (mul_last) state_next = DONE;
            DONE:    if (rsp_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            cnt     <= '0;
            id_q    <= 1'b0;
            valid_q <= 1'b0;
            sum_q   <= '0;
            prod_q  <= '0;
            count_q <= '0;
        end else begin
            if (accept) begin
                a_q   <= sel_a;
                b_q   <= sel_b;
                id_q  <= grant1;
                sum_q <= {1'b0, sel_a} + {1'b0, sel_b};
                acc   <= '0;
                cnt   <= '0;
                ptr   <= !grant1;
            end
            if (state == MUL) begin
                acc <= acc + addend;
                cnt <= cnt + 1'b1;
                // The last partial product goes straight to the result register.
                if (mul_last) begin
                    prod_q  <= acc + addend;
                    valid_q <= 1'b1;
                end
            end
            if (rsp_fire) begin
                valid_q <= 1'b0;
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign bus.req0_ready  = (state == IDLE) && grant0;
    assign bus.req1_ready  = (state == IDLE) && grant1;
    assign bus.rsp_valid   = valid_q;
    assign bus.rsp_id      = id_q;
    assign bus.rsp_sum     = sum_q;
    assign bus.rsp_product = prod_q;
    assign bus.busy        = (state != IDLE);
    assign bus.op_count    = count_q;
endmodule

// File: tb/tb_arith_share_arbiter.sv
// tb/tb_arith_share_arbiter.sv - self-checking bench for arith_share_arbiter
module tb_arith_share_arbiter;
    localparam int W = 8;

    typedef struct {
        logic             id;
        logic [W-1:0]     a;
        logic [W-1:0]     b;
        logic [W:0]       sum;
        logic [2*W-1:0]   prod;
        int               hold;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass = 0;
    int   exp_count = 0;

    always #5 clk = ~clk;

    arith_share_arbiter_if #(.WIDTH(W)) bus();
    arith_share_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic idle_inputs;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_count = 0;
    endtask

    task automatic run_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W:0] es, input logic [2*W-1:0] ep, input int hold);
        int   lat;
        logic ok;
        logic [31:0] snap;
        if (id) begin bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; end
        else    begin bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; end
        settle();
        chk("accept_ready", 32'({bus.req1_ready, bus.req0_ready}), id ? 32'd2 : 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        settle();
        chk("busy_after_accept", 32'(bus.busy), 32'd1);
        lat = 0;
        while (!bus.rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'(W));
        chk("rsp_id", 32'(bus.rsp_id), 32'(id));
        chk("rsp_sum", 32'(bus.rsp_sum), 32'(es));
        chk("rsp_product", 32'(bus.rsp_product), 32'(ep));
        ok = 1'b1;
        snap = 32'({bus.rsp_id, bus.rsp_sum, bus.rsp_product});
        for (int i = 0; i < hold; i++) begin
            bus.req0_valid = 1'b1; bus.req0_a = ~a;
            bus.req1_valid = 1'b1; bus.req1_b = ~b;
            settle();
            if (bus.req0_ready || bus.req1_ready || !bus.rsp_valid ||
                32'({bus.rsp_id, bus.rsp_sum, bus.rsp_product}) != snap) ok = 1'b0;
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        if (hold > 0) chk("hold_stable", 32'(ok), 32'd1);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        exp_count++;
        settle();
        chk("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
        chk("op_count", 32'(bus.op_count), 32'(exp_count));
        chk("busy_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[8];
        logic [31:0] rsps[$];
        int          grants[$];
        int          acc0, acc1, cyc;
        logic        f0, f1, seen;

        vecs[0] = '{1'b0, 8'd10,  8'd33,  9'd43,  16'd330,   0};
        vecs[1] = '{1'b1, 8'd5,   8'd6,   9'd11,  16'd30,    0};
        vecs[2] = '{1'b0, 8'd7,   8'd8,   9'd15,  16'd56,    0};
        vecs[3] = '{1'b1, 8'd132, 8'd4,   9'd136, 16'd528,   20};
        vecs[4] = '{1'b0, 8'd255, 8'd255, 9'd510, 16'd65025, 0};
        vecs[5] = '{1'b1, 8'd0,   8'd200, 9'd200, 16'd0,     0};
        vecs[6] = '{1'b0, 8'd1,   8'd1,   9'd2,   16'd1,     3};
        vecs[7] = '{1'b1, 8'd128, 8'd2,   9'd130, 16'd256,   0};

        do_reset();
        settle();
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_op_count", 32'(bus.op_count), 32'd0);
        chk("reset_rsp", 32'({bus.rsp_id, bus.rsp_sum, bus.rsp_product}), 32'd0);

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].prod, vecs[i].hold);

        // Both requesters valid from reset with the consumer always ready.
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_a = 8'd5; bus.req0_b = 8'd6;
        bus.req1_valid = 1'b1; bus.req1_a = 8'd7; bus.req1_b = 8'd8;
        bus.rsp_ready  = 1'b1;
        acc0 = -100; acc1 = 0;
        for (cyc = 0; cyc < 60 && rsps.size() < 2; cyc++) begin
            settle();
            f0 = bus.req0_valid && bus.req0_ready;
            f1 = bus.req1_valid && bus.req1_ready;
            if (f0) acc0 = cyc;
            if (f1) acc1 = cyc;
            if (bus.rsp_valid && bus.rsp_ready)
                rsps.push_back(32'({bus.rsp_id, bus.rsp_sum, bus.rsp_product}));
            tick();
            if (f0) bus.req0_valid = 1'b0;
            if (f1) bus.req1_valid = 1'b0;
        end
        chk("pair_rsp_count", 32'(rsps.size()), 32'd2);
        if (rsps.size() >= 2) begin
            chk("pair_first", rsps[0], 32'({1'b0, 9'd11, 16'd30}));
            chk("pair_second", rsps[1], 32'({1'b1, 9'd15, 16'd56}));
        end
        chk("pair_accept_gap", 32'(acc1 - acc0), 32'd10);
        bus.rsp_ready = 1'b0;

        // Reset in the middle of a multiply.
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_a = 8'd3; bus.req0_b = 8'd5;
        bus.req1_valid = 1'b1; bus.req1_a = 8'd9; bus.req1_b = 8'd9;
        settle();
        chk("mid_rst_first_grant", 32'({bus.req1_ready, bus.req0_ready}), 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        chk("mid_rst_ptr", 32'({bus.req1_ready, bus.req0_ready}), 32'd1);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.rsp_valid || bus.busy) seen = 1'b1;
        end
        chk("mid_rst_no_stale_rsp", 32'(seen), 32'd0);
        chk("mid_rst_op_count", 32'(bus.op_count), 32'd0);

        // Both held valid continuously: grants must alternate.
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_a = 8'($urandom); bus.req0_b = 8'($urandom);
        bus.req1_valid = 1'b1; bus.req1_a = 8'($urandom); bus.req1_b = 8'($urandom);
        bus.rsp_ready  = 1'b1;
        for (cyc = 0; cyc < 120 && grants.size() < 4; cyc++) begin
            settle();
            if (bus.req0_ready) grants.push_back(0);
            if (bus.req1_ready) grants.push_back(1);
            tick();
        end
        chk("alt_grant_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < grants.size(); i++)
            chk("alt_grant", 32'(grants[i]), 32'(i % 2));
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        for (cyc = 0; cyc < 30 && bus.busy; cyc++) tick();
        chk("alt_drain", 32'(bus.busy), 32'd0);

        // Randomised traffic against a transaction-level model.
        begin
            logic           v[2];
            logic [W-1:0]   ra[2], rb[2];
            logic           m_idle, m_done, m_ptr, gid;
            int             m_left, m_cnt;
            logic [31:0]    m_exp, e;
            logic [W:0]     s;
            logic [2*W-1:0] p;

            do_reset();
            v[0] = 1'b0; v[1] = 1'b0;
            ra[0] = '0; rb[0] = '0; ra[1] = '0; rb[1] = '0;
            m_idle = 1'b1; m_done = 1'b0; m_ptr = 1'b0; m_left = 0; m_cnt = 0; m_exp = '0;
            for (int c = 0; c < 900; c++) begin
                for (int r = 0; r < 2; r++) begin
                    if (!v[r] && ($urandom % 3 == 0)) begin
                        v[r] = 1'b1; ra[r] = 8'($urandom); rb[r] = 8'($urandom);
                    end else if (v[r] && ($urandom % 4 == 0)) begin
                        ra[r] = 8'($urandom); rb[r] = 8'($urandom);
                    end
                end
                bus.req0_valid = v[0]; bus.req0_a = ra[0]; bus.req0_b = rb[0];
                bus.req1_valid = v[1]; bus.req1_a = ra[1]; bus.req1_b = rb[1];
                bus.rsp_ready  = 1'($urandom % 2);
                settle();
                e = 32'd0;
                if (m_idle) begin
                    if (v[0] && v[1]) e = m_ptr ? 32'd2 : 32'd1;
                    else if (v[0])    e = 32'd1;
                    else if (v[1])    e = 32'd2;
                end
                chk("rnd_ready", 32'({bus.req1_ready, bus.req0_ready}), e);
                chk("rnd_rsp_valid", 32'(bus.rsp_valid), 32'(m_done));
                chk("rnd_busy", 32'(bus.busy), 32'(!m_idle));
                if (m_done) chk("rnd_rsp", 32'({bus.rsp_id, bus.rsp_sum, bus.rsp_product}), m_exp);
                if (e != 0) begin
                    gid    = (e == 32'd2);
                    s      = (W+1)'(ra[gid]) + (W+1)'(rb[gid]);
                    p      = (2*W)'(ra[gid]) * (2*W)'(rb[gid]);
                    m_exp  = 32'({gid, s, p});
                    m_ptr  = !gid;
                    m_idle = 1'b0;
                    m_left = W;
                    v[gid] = 1'b0;
                end else if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) m_done = 1'b1;
                end else if (m_done && bus.rsp_ready) begin
                    m_done = 1'b0;
                    m_idle = 1'b1;
                    m_cnt++;
                end
                tick();
            end
            settle();
            chk("rnd_op_count", 32'(bus.op_count), 32'(m_cnt));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
